// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter:
// FSM state encoding, data-side command codes and parameter defaults.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_I = 2'b01,
        BUSY_D = 2'b10
    } arb_state_e;

    localparam logic [1:0] DMC_NOP = 2'b00;
    localparam logic [1:0] DMC_RD  = 2'b01;
    localparam logic [1:0] DMC_WR  = 2'b10;

    localparam int          DEFAULT_MAX_WAIT   = 64;
    localparam logic [31:0] DEFAULT_ABORT_DATA = 32'hDEADBEEF;

    // Only reads and writes reach memory; nop and the reserved code do not.
    function automatic logic dmc_is_mem(input logic [1:0] dmc);
        return (dmc == DMC_RD) || (dmc == DMC_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// 8-bit saturating wait counter; flags when a granted transaction has
// waited MAX_WAIT-1 cycles without an acknowledge.
module mem_wait_timer
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(MAX_WAIT - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 8'd0;
        end else if (enable && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Define ARB_RR_EN for round-robin arbitration; default is D-over-I priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          MAX_WAIT   = DEFAULT_MAX_WAIT,
    parameter logic [31:0] ABORT_DATA = DEFAULT_ABORT_DATA
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_req,
    input  logic [1:0]  d_dmc,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        err
);

    arb_state_e  state_q, state_d;
    logic        m_req_q, m_req_d;
    logic        m_we_q, m_we_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        i_ready_q, i_ready_d;
    logic        d_ready_q, d_ready_d;
    logic        err_q, err_d;

    logic        timer_clear;
    logic        timer_en;
    logic        timer_expired;

    logic        i_valid;
    logic        d_active;
    logic        d_valid;
    logic        d_nop;
    logic        grant_i;
    logic        grant_d;

    // A requester whose ready is high this cycle was just served; skip it.
    assign i_valid  = i_req && !i_ready_q;
    assign d_active = d_req && !d_ready_q;
    assign d_valid  = d_active && dmc_is_mem(d_dmc);
    assign d_nop    = d_active && !dmc_is_mem(d_dmc);

`ifdef ARB_RR_EN
    logic last_grant_q, last_grant_d;

    assign grant_d = d_valid && (!i_valid || !last_grant_q);
`else
    assign grant_d = d_valid;
`endif
    assign grant_i = i_valid && !grant_d;

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (CLK),
        .rst_n   (RESET),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        m_req_d     = m_req_q;
        m_we_d      = m_we_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        err_d       = err_q;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
`ifdef ARB_RR_EN
        last_grant_d = last_grant_q;
`endif

        case (state_q)
            IDLE: begin
                if (d_nop) begin
                    d_ready_d = 1'b1;
                end
                if (grant_d) begin
                    m_req_d     = 1'b1;
                    m_we_d      = (d_dmc == DMC_WR);
                    m_addr_d    = d_addr;
                    m_wdata_d   = d_wdata;
                    timer_clear = 1'b1;
                    state_d     = BUSY_D;
`ifdef ARB_RR_EN
                    last_grant_d = 1'b1;
`endif
                end else if (grant_i) begin
                    m_req_d     = 1'b1;
                    m_we_d      = 1'b0;
                    m_addr_d    = i_addr;
                    m_wdata_d   = 32'd0;
                    timer_clear = 1'b1;
                    state_d     = BUSY_I;
`ifdef ARB_RR_EN
                    last_grant_d = 1'b0;
`endif
                end
            end

            BUSY_I, BUSY_D: begin
                // An acknowledge in the timeout cycle still completes normally.
                if (m_ack || timer_expired) begin
                    m_req_d = 1'b0;
                    m_we_d  = 1'b0;
                    state_d = IDLE;
                    if (!m_ack) begin
                        err_d = 1'b1;
                    end
                    if (state_q == BUSY_I) begin
                        i_ready_d = 1'b1;
                        i_rdata_d = m_ack ? m_rdata : ABORT_DATA;
                    end else begin
                        d_ready_d = 1'b1;
                        if (!m_we_q) begin
                            d_rdata_d = m_ack ? m_rdata : ABORT_DATA;
                        end
                    end
                end else begin
                    timer_en = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                m_req_d = 1'b0;
                m_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= 32'd0;
            m_wdata_q <= 32'd0;
            i_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ready_q <= i_ready_d;
            d_ready_q <= d_ready_d;
            err_q     <= err_d;
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            last_grant_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign i_ready = i_ready_q;
    assign d_ready = d_ready_q;
    assign err     = err_q;

endmodule
